// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - n-bit universal shift register with multi-cycle rotate-by-amount.
// Optional even-parity output of Q is enabled by defining USR_PARITY_EN.
module universal_shift_register #(
  parameter int n  = 8,
  parameter int AW = $clog2(n) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [n-1:0]  I,
  input  logic [2:0]    mode,
  input  logic          sin_l,
  input  logic          sin_r,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  output logic [n-1:0]  Q,
  output logic          sout_l,
  output logic          sout_r,
  output logic          busy,
  output logic          done,
  output logic          parity
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ROT  = 1'b1;

  localparam logic [AW-1:0] AMT_MAX = AW'(n);
  localparam logic [AW-1:0] AMT_ONE = AW'(1);

  logic [0:0]    state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          dir_q, dir_nx;
  logic          done_nx;
  logic [n-1:0]  q_nx;
  logic [n-1:0]  rotl, rotr;

  assign rotl = {Q[n-2:0], Q[n-1]};
  assign rotr = {Q[0], Q[n-1:1]};

  always_comb begin
    q_nx     = Q;
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    done_nx  = 1'b0;
    if (state == ROT) begin
      // Inputs are ignored here; only the latched direction and count matter.
      q_nx   = dir_q ? rotr : rotl;
      cnt_nx = cnt - AMT_ONE;
      if (cnt == AMT_ONE) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    end else begin
      case (mode)
        3'b000: q_nx = Q;
        3'b001: q_nx = I;
        3'b010: q_nx = {Q[n-2:0], sin_r};
        3'b011: q_nx = {sin_l, Q[n-1:1]};
        3'b100: q_nx = rotl;
        3'b101: q_nx = rotr;
        3'b110: q_nx = '0;
        default: begin
          if (amt == '0) begin
            done_nx = 1'b1;
          end else begin
            cnt_nx   = (amt > AMT_MAX) ? AMT_MAX : amt;
            dir_nx   = dir;
            state_nx = ROT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q     <= '0;
      state <= IDLE;
      cnt   <= '0;
      dir_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      Q     <= q_nx;
      state <= state_nx;
      cnt   <= cnt_nx;
      dir_q <= dir_nx;
      done  <= done_nx;
    end
  end

  assign busy   = (state == ROT);
  assign sout_l = Q[n-1];
  assign sout_r = Q[0];

`ifdef USR_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else     parity <= ^q_nx;
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - scoreboard bench for universal_shift_register.
module tb_universal_shift_register;

  localparam int N  = 8;
  localparam int AW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  I;
  logic [2:0]    mode;
  logic          sin_l, sin_r;
  logic [AW-1:0] amt;
  logic          dir;
  logic [N-1:0]  Q;
  logic          sout_l, sout_r, busy, done, parity;

  universal_shift_register #(.n(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .I(I), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .amt(amt), .dir(dir), .Q(Q), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done), .parity(parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   q;
    logic busy;
    logic done;
    logic par;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: value, plus a pending rotation described as (base, total, steps taken).
  int   mq, base, total, j;
  logic mdir, mdone;
  localparam int MASK = (1 << N) - 1;

  function automatic int rot(input int v, input int k, input logic d);
    if (!d) return ((v << k) | (v >> (N - k))) & MASK;
    else    return ((v >> k) | (v << (N - k))) & MASK;
  endfunction

  function automatic logic par_of(input int v);
`ifdef USR_PARITY_EN
    return ^v[N-1:0];
`else
    return 1'b0 | (v[31] & 1'b0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq = 0; base = 0; total = 0; j = 0; mdir = 1'b0; mdone = 1'b0;
  endtask

  task automatic model_step(input int m, input int d, input logic sl, input logic sr,
                            input int a, input logic dr);
    mdone = 1'b0;
    if (j < total) begin
      j++;
      mq = rot(base, j, mdir);
      if (j == total) mdone = 1'b1;
    end else begin
      case (m)
        0: ;
        1: mq = d & MASK;
        2: mq = ((mq << 1) | int'(sr)) & MASK;
        3: mq = (int'(sl) << (N - 1)) | (mq >> 1);
        4: mq = rot(mq, 1, 1'b0);
        5: mq = rot(mq, 1, 1'b1);
        6: mq = 0;
        default: begin
          total = (a > N) ? N : a;
          j = 0;
          base = mq;
          mdir = dr;
          if (total == 0) mdone = 1'b1;
        end
      endcase
    end
  endtask

  task automatic step(input int m, input int d, input logic sl, input logic sr,
                      input int a, input logic dr);
    exp_t e;
    @(negedge clk);
    mode = m[2:0]; I = d[N-1:0]; sin_l = sl; sin_r = sr; amt = a[AW-1:0]; dir = dr;
    model_step(m, d, sl, sr, a, dr);
    e.q = mq; e.busy = (j < total); e.done = mdone; e.par = par_of(mq);
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: every clock edge presents a new register state.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q", 32'(Q), 32'(e.q));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("parity", 32'(parity), 32'(e.par));
      chk("sout_l", 32'(sout_l), 32'(e.q[N-1]));
      chk("sout_r", 32'(sout_r), 32'(e.q[0]));
    end
  end

  initial begin
    rst = 1'b1; I = '0; mode = '0; sin_l = 0; sin_r = 0; amt = '0; dir = 0;
    model_reset();
    #2;
    chk("reset_q", 32'(Q), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_parity", 32'(parity), 0);
    @(negedge clk); rst = 1'b0;

    // Load then hold
    step(1, 'h96, 0, 0, 0, 0);
    repeat (3) step(0, 'h00, 0, 0, 0, 0);

    // Single-step shifts and rotates
    step(1, 'h81, 0, 0, 0, 0);
    step(2, 0, 0, 1, 0, 0);
    step(3, 0, 1, 0, 0, 0);
    step(4, 0, 0, 0, 0, 0);
    step(5, 0, 0, 0, 0, 0);
    step(6, 0, 0, 0, 0, 0);

    // Rotate by 3 left, with other commands during busy
    step(1, 'h01, 0, 0, 0, 0);
    step(7, 0, 0, 0, 3, 0);
    step(1, 'hFF, 1, 1, 5, 1);
    step(6, 0, 0, 0, 0, 0);
    step(3, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // amt=0 and saturated amt
    step(7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 'h5C, 0, 0, 0, 0);
    step(7, 0, 0, 0, 9, 1);
    repeat (9) step(0, 0, 0, 0, 0, 0);

    // Parity loads
    step(1, 'h07, 0, 0, 0, 0);
    step(1, 'h03, 0, 0, 0, 0);

    // Mid-cycle reset during a rotation: no done afterwards
    step(1, 'hA5, 0, 0, 0, 0);
    step(7, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_q", 32'(Q), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_parity", 32'(parity), 0);
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    chk("rst_held_q", 32'(Q), 0);
    @(negedge clk); rst = 1'b0;
    repeat (6) step(0, 0, 0, 0, 0, 0);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      step(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           int'($urandom_range(0, (1 << AW) - 1)), logic'($urandom_range(0, 1)));
    end

    for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
